// File: rtl/arinc429_rx.sv
// arinc429_rx: ARINC 429 bipolar return-to-zero line receiver.
// Recovers 32-bit words from RxA/RxB and flags parity and framing errors.
module arinc429_rx #(
    parameter int CLKS_PER_BIT = 240,
    parameter int GAP_BITS     = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        RxA,
    input  logic        RxB,
    output logic [31:0] Out,
    output logic        valid,
    output logic        parity_err,
    output logic        frame_err
);
    localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
    localparam int PW      = $clog2(GAP_CYC + 1);

    localparam logic [PW-1:0] GAP_LAST = PW'(GAP_CYC - 1);
    localparam logic [PW-1:0] PH_MAX   = PW'(GAP_CYC);
    localparam logic [PW-1:0] HI_MIN   = PW'(CLKS_PER_BIT / 4);
    localparam logic [PW-1:0] HI_MAX   = PW'(3 * CLKS_PER_BIT / 4);
    localparam logic [PW-1:0] LO_MAX   = PW'(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        SYNC,
        WAIT_BIT,
        HIGH
    } state_t;

    typedef enum logic [1:0] {
        SYM_NULL = 2'b00,
        SYM_ZERO = 2'b01,
        SYM_ONE  = 2'b10,
        SYM_ILL  = 2'b11
    } sym_t;

    logic [1:0]    a_sync;
    logic [1:0]    b_sync;
    sym_t          sym;
    state_t        state;
    state_t        state_n;
    logic [PW-1:0] phase_cnt;
    logic [PW-1:0] phase_n;
    logic [PW-1:0] phase_inc;
    logic [5:0]    bit_cnt;
    logic [5:0]    bit_n;
    logic [31:0]   shreg;
    logic [31:0]   shreg_n;
    logic [31:0]   word;
    logic          cur_bit;
    logic          cur_n;
    logic [31:0]   out_n;
    logic          valid_n;
    logic          perr_n;
    logic          ferr_n;
    logic          abort;
    logic          same_sym;

    assign sym       = sym_t'({a_sync[1], b_sync[1]});
    assign phase_inc = (phase_cnt == PH_MAX) ? phase_cnt : phase_cnt + 1'b1;
    assign same_sym  = (sym == SYM_ONE && cur_bit) || (sym == SYM_ZERO && !cur_bit);

    // Two-flop synchronisers for the asynchronous line legs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            a_sync <= 2'b00;
            b_sync <= 2'b00;
        end else begin
            a_sync <= {a_sync[0], RxA};
            b_sync <= {b_sync[0], RxB};
        end
    end

    // Next-state, counter and output decode for the bit framer.
    always_comb begin
        state_n = state;
        phase_n = phase_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        cur_n   = cur_bit;
        out_n   = Out;
        valid_n = 1'b0;
        perr_n  = 1'b0;
        ferr_n  = 1'b0;
        abort   = 1'b0;
        word    = shreg;
        word[bit_cnt[4:0]] = cur_bit;

        case (state)
            SYNC: begin
                if (sym == SYM_NULL) begin
                    if (phase_cnt >= GAP_LAST) begin
                        state_n = WAIT_BIT;
                        phase_n = '0;
                        bit_n   = '0;
                        shreg_n = '0;
                    end else begin
                        phase_n = phase_inc;
                    end
                end else begin
                    phase_n = '0;
                end
            end
            WAIT_BIT: begin
                case (sym)
                    SYM_ONE, SYM_ZERO: begin
                        cur_n   = (sym == SYM_ONE);
                        phase_n = '0;
                        state_n = HIGH;
                    end
                    SYM_ILL: begin
                        ferr_n = (bit_cnt != 6'd0);
                        abort  = 1'b1;
                    end
                    default: begin
                        if (bit_cnt != 6'd0) begin
                            if (phase_cnt > LO_MAX) begin
                                ferr_n = 1'b1;
                                abort  = 1'b1;
                            end else begin
                                phase_n = phase_inc;
                            end
                        end
                    end
                endcase
            end
            HIGH: begin
                if (same_sym) begin
                    if (phase_cnt > HI_MAX) begin
                        ferr_n = 1'b1;
                        abort  = 1'b1;
                    end else begin
                        phase_n = phase_inc;
                    end
                end else if (sym == SYM_NULL) begin
                    if (phase_cnt < HI_MIN) begin
                        ferr_n = 1'b1;
                        abort  = 1'b1;
                    end else if (bit_cnt == 6'd31) begin
                        out_n   = word;
                        valid_n = 1'b1;
                        perr_n  = ~^word;
                        state_n = SYNC;
                        phase_n = '0;
                        bit_n   = '0;
                        shreg_n = '0;
                    end else begin
                        shreg_n = word;
                        bit_n   = bit_cnt + 1'b1;
                        phase_n = '0;
                        state_n = WAIT_BIT;
                    end
                end else begin
                    ferr_n = 1'b1;
                    abort  = 1'b1;
                end
            end
            default: begin
                abort = 1'b1;
            end
        endcase

        if (abort) begin
            state_n = SYNC;
            phase_n = '0;
            bit_n   = '0;
            shreg_n = '0;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= SYNC;
            phase_cnt  <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            cur_bit    <= 1'b0;
            Out        <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            phase_cnt  <= phase_n;
            bit_cnt    <= bit_n;
            shreg      <= shreg_n;
            cur_bit    <= cur_n;
            Out        <= out_n;
            valid      <= valid_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
        end
    end
endmodule

// File: tb/tb_arinc429_rx.sv
// tb_arinc429_rx: scoreboard bench for the ARINC 429 receiver.
// Stimulus predicts word/error events; a monitor pops and compares.
module tb_arinc429_rx;
    localparam int CPB     = 240;
    localparam int GAP     = 4;
    localparam int GAP_CYC = GAP * CPB;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        RxA;
    logic        RxB;
    logic [31:0] Out;
    logic        valid;
    logic        parity_err;
    logic        frame_err;

    arinc429_rx #(
        .CLKS_PER_BIT(CPB),
        .GAP_BITS    (GAP)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .RxA       (RxA),
        .RxB       (RxB),
        .Out       (Out),
        .valid     (valid),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    always #5 Clk = ~Clk;

    typedef enum int {F_NONE, F_TRUNC, F_GLITCH, F_ILLEG, F_LONGHI, F_RESET} fault_t;

    typedef struct {
        bit          is_err;
        logic [31:0] w;
        bit          perr;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    bit          armed = 1'b0;
    int          run = 0;
    bit          done = 1'b0;
    logic        rst_q = 1'b0;
    logic [31:0] prev_out = '0;
    logic        prev_valid = 1'b0;
    logic        prev_ferr = 1'b0;

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Reference: receiver is listening once a full NULL gap has elapsed
    // since the last word, error or reset.
    task automatic drive(input logic a, input logic b, input int n);
        RxA = a;
        RxB = b;
        if (!a && !b) begin
            run += n;
            if (run >= GAP_CYC) armed = 1'b1;
        end else begin
            run = 0;
        end
        tick(n);
    endtask

    task automatic expect_evt(input bit is_err, input logic [31:0] w);
        exp_t e;
        e.is_err = is_err;
        e.w      = w;
        e.perr   = (($countones(w) % 2) == 0);
        q.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] w, input bit fixed,
                             input fault_t f, input int fb);
        int hi;
        int lo;
        int extra;
        bit v;
        if (armed) begin
            if (f == F_NONE) expect_evt(1'b0, w);
            else if (f != F_RESET) expect_evt(1'b1, w);
        end
        armed = 1'b0;
        run   = 0;
        extra = -1;
        for (int i = 0; i < 32; i++) begin
            hi = fixed ? 120 : int'($urandom_range(70, 170));
            lo = fixed ? 120 : int'($urandom_range(10, 40));
            v  = w[i];
            if (extra == 0) break;
            if (extra > 0) extra--;
            if (i == fb && f != F_NONE) begin
                case (f)
                    F_TRUNC: break;
                    F_GLITCH: begin
                        drive(1'b1, 1'b0, 30);
                        drive(1'b0, 1'b0, lo);
                        extra = 4;
                    end
                    F_ILLEG: begin
                        drive(v, !v, 50);
                        drive(1'b1, 1'b1, 20);
                        drive(1'b0, 1'b0, lo);
                        extra = 4;
                    end
                    F_LONGHI: begin
                        drive(v, !v, 200);
                        drive(1'b0, 1'b0, lo);
                        break;
                    end
                    F_RESET: begin
                        drive(v, !v, 60);
                        Rst = 1'b1;
                        tick(1);
                        Rst   = 1'b0;
                        armed = 1'b0;
                        run   = 0;
                        drive(v, !v, 40);
                        drive(1'b0, 1'b0, lo);
                        break;
                    end
                    default: ;
                endcase
            end else begin
                drive(v, !v, hi);
                drive(1'b0, 1'b0, lo);
            end
        end
    endtask

    always @(posedge Clk) rst_q <= Rst;

    // Monitor: compares every DUT event against the scoreboard queue.
    always @(negedge Clk) begin
        if (done) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL drain: pending events=%0d required=0", q.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end else if (rst_q) begin
            checks += 4;
            if (Out !== 32'h0) begin
                errors++;
                $display("FAIL rst_out: got=%h required=0", Out);
            end
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_valid: got=%b required=0", valid);
            end
            if (parity_err !== 1'b0) begin
                errors++;
                $display("FAIL rst_perr: got=%b required=0", parity_err);
            end
            if (frame_err !== 1'b0) begin
                errors++;
                $display("FAIL rst_ferr: got=%b required=0", frame_err);
            end
        end else begin
            if (valid || frame_err) begin
                checks++;
                if ((valid && frame_err) || (valid && prev_valid) ||
                    (frame_err && prev_ferr)) begin
                    errors++;
                    $display("FAIL pulse: valid=%b frame_err=%b prev=%b/%b required single 1-cycle pulse",
                             valid, frame_err, prev_valid, prev_ferr);
                end
            end
            if (valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: Out=%h required no event", Out);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.is_err) begin
                        errors++;
                        $display("FAIL event_kind: got valid required frame_err");
                    end else begin
                        checks += 2;
                        if (Out !== mon_e.w) begin
                            errors++;
                            $display("FAIL word: got=%h required=%h", Out, mon_e.w);
                        end
                        if (parity_err !== mon_e.perr) begin
                            errors++;
                            $display("FAIL parity: got=%b required=%b word=%h",
                                     parity_err, mon_e.perr, mon_e.w);
                        end
                    end
                end
            end
            if (frame_err) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ferr: got frame_err required no event");
                end else begin
                    mon_e = q.pop_front();
                    if (!mon_e.is_err) begin
                        errors++;
                        $display("FAIL event_kind: got frame_err required valid %h", mon_e.w);
                    end
                end
            end
            if (Out !== prev_out) begin
                checks++;
                if (!valid) begin
                    errors++;
                    $display("FAIL out_stable: got=%h prev=%h required change only with valid",
                             Out, prev_out);
                end
            end
        end
        prev_out   = Out;
        prev_valid = valid;
        prev_ferr  = frame_err;
    end

    initial begin
        logic [31:0] w;
        Rst = 1'b1;
        RxA = 1'b0;
        RxB = 1'b0;
        tick(2);
        Rst = 1'b0;

        drive(1'b0, 1'b0, 960);
        send_word(32'hABDCABAA, 1'b1, F_NONE, 0);
        drive(1'b0, 1'b0, 1100);
        send_word(32'hABDCABAB, 1'b1, F_NONE, 0);
        drive(1'b0, 1'b0, 1100);

        send_word(32'hABDCABAA, 1'b0, F_TRUNC, 10);
        drive(1'b0, 1'b0, 500);
        drive(1'b0, 1'b0, 960);
        send_word(32'hABDCABAA, 1'b0, F_NONE, 0);
        drive(1'b0, 1'b0, 1100);

        w = $urandom;
        send_word(w, 1'b0, F_GLITCH, int'($urandom_range(1, 8)));
        drive(1'b0, 1'b0, 1100);
        w = $urandom;
        send_word(w, 1'b0, F_ILLEG, 5);
        drive(1'b0, 1'b0, 1100);
        w = $urandom;
        send_word(w, 1'b0, F_LONGHI, int'($urandom_range(0, 8)));
        drive(1'b0, 1'b0, 1100);

        w = $urandom;
        send_word(w, 1'b0, F_NONE, 0);
        drive(1'b0, 1'b0, 500);
        w = $urandom;
        send_word(w, 1'b0, F_NONE, 0);
        drive(1'b0, 1'b0, 1100);
        w = $urandom;
        send_word(w, 1'b0, F_NONE, 0);
        drive(1'b0, 1'b0, 1100);

        w = $urandom;
        send_word(w, 1'b0, F_RESET, 20);
        drive(1'b0, 1'b0, 1100);
        w = $urandom;
        send_word(w, 1'b0, F_NONE, 0);
        drive(1'b0, 1'b0, int'($urandom_range(1000, 1300)));
        w = $urandom;
        send_word(w, 1'b0, F_NONE, 0);
        drive(1'b0, 1'b0, 200);

        done = 1'b1;
    end
endmodule
